// File: rtl/chip_inj_arb.sv
// Injection/ejection scheduler for one two-lane deflection-router stage: ejects at most
// one local flit per cycle, fills a free lane slot from a 4-entry injection queue, and registers both lanes.
module chip_inj_arb #(
    parameter logic [2:0] LOCAL_CODE   = 3'b111,
    parameter int         STARVE_LIMIT = 8,
    parameter int         STARVE_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] lane_in0,
    input  logic [9:0] lane_in1,
    input  logic [8:0] inj_data,
    input  logic       inj_valid,
    output logic       inj_ready,
    output logic [9:0] lane_out0,
    output logic [9:0] lane_out1,
    output logic       ej_valid,
    output logic [9:0] ej_flit,
    output logic       starve
);

    localparam int QDEPTH = 4;

    // Lane inputs gathered into an array so per-lane logic can be generated.
    logic [9:0] lane_in   [2];
    logic [1:0] lane_local;

    assign lane_in[0] = lane_in0;
    assign lane_in[1] = lane_in1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_local
            assign lane_local[gi] = lane_in[gi][9] && (lane_in[gi][8:6] == LOCAL_CODE);
        end
    endgenerate

    // Injection queue state.
    logic [8:0] fifo_mem_q [QDEPTH];
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] count_q,  count_d;
    logic       push, pop;

    // Arbitration and output state.
    logic                ej_ptr_q,    ej_ptr_d;
    logic [9:0]          lane0_q,     lane0_d;
    logic [9:0]          lane1_q,     lane1_d;
    logic                ej_valid_q,  ej_valid_d;
    logic [9:0]          ej_flit_q,   ej_flit_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                starve_q,    starve_d;

    logic       ej_any;
    logic       ej_sel;
    logic [9:0] slot0, slot1;
    logic [8:0] q_head;

    assign inj_ready = (count_q < 3'(QDEPTH));
    assign push      = inj_valid && inj_ready;
    assign q_head    = fifo_mem_q[rd_ptr_q];

    // Ejection choice: a lone local flit wins outright; a contest is settled by ej_ptr.
    always_comb begin
        ej_any   = |lane_local;
        ej_sel   = 1'b0;
        ej_ptr_d = ej_ptr_q;
        if (&lane_local) begin
            ej_sel   = ej_ptr_q;
            ej_ptr_d = ~ej_ptr_q;
        end else if (lane_local[1]) begin
            ej_sel = 1'b1;
        end
    end

    // Remove the ejected flit, then drop the queue head into the lowest empty slot.
    // The head is placed after ejection is decided, so it can never be ejected this cycle.
    always_comb begin
        slot0      = lane_in0;
        slot1      = lane_in1;
        ej_valid_d = ej_any;
        ej_flit_d  = 10'b0;
        pop        = 1'b0;

        if (ej_any) begin
            if (ej_sel) begin
                ej_flit_d = lane_in1;
                slot1     = 10'b0;
            end else begin
                ej_flit_d = lane_in0;
                slot0     = 10'b0;
            end
        end

        if (count_q != 3'd0) begin
            if (!slot0[9]) begin
                slot0 = {1'b1, q_head};
                pop   = 1'b1;
            end else if (!slot1[9]) begin
                slot1 = {1'b1, q_head};
                pop   = 1'b1;
            end
        end

        lane0_d = slot0;
        lane1_d = slot1;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Starvation: blocked cycles with a waiting head, saturating; the flag lags the counter by one edge.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if ((count_q == 3'd0) || pop) begin
            starve_cnt_d = '0;
        end else if (!(&starve_cnt_q)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
        starve_d = (starve_cnt_q >= STARVE_W'(STARVE_LIMIT));
    end

    // Queue storage needs no reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= inj_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= 2'd0;
            wr_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            ej_ptr_q     <= 1'b0;
            lane0_q      <= 10'b0;
            lane1_q      <= 10'b0;
            ej_valid_q   <= 1'b0;
            ej_flit_q    <= 10'b0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            ej_ptr_q     <= ej_ptr_d;
            lane0_q      <= lane0_d;
            lane1_q      <= lane1_d;
            ej_valid_q   <= ej_valid_d;
            ej_flit_q    <= ej_flit_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign lane_out0 = lane0_q;
    assign lane_out1 = lane1_q;
    assign ej_valid  = ej_valid_q;
    assign ej_flit   = ej_flit_q;
    assign starve    = starve_q;

endmodule
